// File: rtl/fpu_wb_stage.sv
// fpu_wb_stage: buffers FPU results with mapped fflags and commits them to writeback and the fflags register.
module fpu_wb_stage #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 5
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [31:0]              in_result_i,
   input  logic [7:0]               in_status_i,
   input  logic                     in_flags_en_i,
   input  logic                     in_is_div_i,
   input  logic [ADDR_W-1:0]        in_rd_addr_i,
   input  logic                     in_dest_fp_i,
   input  logic                     flush_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [31:0]              out_result_o,
   output logic [ADDR_W-1:0]        out_rd_addr_o,
   output logic                     out_dest_fp_o,
   input  logic                     csr_we_i,
   input  logic [4:0]               csr_wdata_i,
   output logic [4:0]               fflags_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [31:0]       res_mem [DEPTH];
   logic [ADDR_W-1:0] rd_mem  [DEPTH];
   logic              fp_mem  [DEPTH];
   logic [4:0]        flg_mem [DEPTH];
   logic [PW-1:0]     wptr, rptr;
   logic [CW-1:0]     cnt;
   logic [4:0]        fflags_q, flg_in, fflags_next;
   logic              push, pop, empty;
   always_comb begin
      empty         = (cnt == '0);
      in_ready_o    = (cnt != CW'(DEPTH));
      out_valid_o   = !empty;
      push          = in_valid_i && in_ready_o && !flush_i;
      pop           = out_valid_o && out_ready_i && !flush_i;
      // DW status -> {NV,DZ,OF,UF,NX}; UF only counts when the result is also inexact
      flg_in        = {in_status_i[2], in_status_i[7] & in_is_div_i, in_status_i[4],
                       in_status_i[3] & in_status_i[5], in_status_i[5]} & {5{in_flags_en_i}};
      fflags_next   = (csr_we_i ? csr_wdata_i : fflags_q) | (pop ? flg_mem[rptr] : 5'd0);
      out_result_o  = empty ? 32'd0 : res_mem[rptr];
      out_rd_addr_o = empty ? '0 : rd_mem[rptr];
      out_dest_fp_o = empty ? 1'b0 : fp_mem[rptr];
      fflags_o      = fflags_q;
      count_o       = cnt;
   end
   always_ff @(posedge clk_i) begin
      if (push) begin
         res_mem[wptr] <= in_result_i;
         rd_mem[wptr]  <= in_rd_addr_i;
         fp_mem[wptr]  <= in_dest_fp_i;
         flg_mem[wptr] <= flg_in;
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr     <= '0;
         rptr     <= '0;
         cnt      <= '0;
         fflags_q <= '0;
      end else begin
         wptr     <= flush_i ? '0 : push ? wptr + PW'(1) : wptr;
         rptr     <= flush_i ? '0 : pop ? rptr + PW'(1) : rptr;
         cnt      <= flush_i ? '0 : cnt + CW'(push) - CW'(pop);
         fflags_q <= fflags_next;
      end
   end
endmodule

// File: tb/tb_fpu_wb_stage.sv
// tb_fpu_wb_stage: directed checks of FIFO handshake, flag mapping/accumulation, flush and reset.
module tb_fpu_wb_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] in_result = '0;
   logic [7:0]  in_status = '0;
   logic        in_flags_en = 1'b0, in_is_div = 1'b0;
   logic [4:0]  in_rd = '0;
   logic        in_fp = 1'b0, flush = 1'b0;
   logic        out_valid, out_ready = 1'b0;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_fp;
   logic        csr_we = 1'b0;
   logic [4:0]  csr_wdata = '0;
   logic [4:0]  fflags;
   logic [1:0]  count;
   int checks = 0, failures = 0;

   fpu_wb_stage #(.DEPTH(2), .ADDR_W(5)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_result_i(in_result),
      .in_status_i(in_status), .in_flags_en_i(in_flags_en), .in_is_div_i(in_is_div),
      .in_rd_addr_i(in_rd), .in_dest_fp_i(in_fp), .flush_i(flush),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_result_o(out_result),
      .out_rd_addr_o(out_rd), .out_dest_fp_o(out_fp),
      .csr_we_i(csr_we), .csr_wdata_i(csr_wdata), .fflags_o(fflags), .count_o(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_set(input logic [31:0] r, input logic [4:0] rd, input logic [7:0] st,
                           input logic fe, input logic dv);
      in_valid = 1'b1; in_result = r; in_rd = rd; in_status = st; in_flags_en = fe; in_is_div = dv;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_ready", 32'(in_ready), 1);
      chk("rst_count", 32'(count), 0);
      chk("rst_fflags", 32'(fflags), 0);
      chk("rst_result", out_result, 0);
      rst_n = 1'b1;
      // single push with downstream ready
      out_ready = 1'b1; in_fp = 1'b1;
      push_set(32'h3F800000, 5'd5, 8'h00, 1'b1, 1'b0);
      tick(); in_valid = 1'b0;
      chk("a_valid", 32'(out_valid), 1);
      chk("a_result", out_result, 32'h3F800000);
      chk("a_rd", 32'(out_rd), 5);
      chk("a_fp", 32'(out_fp), 1);
      tick();
      chk("a_gone", 32'(out_valid), 0);
      chk("a_zero_result", out_result, 0);
      chk("a_fflags", 32'(fflags), 0);
      // backpressure and full
      out_ready = 1'b0; in_fp = 1'b0;
      push_set(32'h11111111, 5'd1, 8'h00, 1'b1, 1'b0);
      tick();
      chk("b1_count", 32'(count), 1);
      chk("b1_ready", 32'(in_ready), 1);
      push_set(32'h22222222, 5'd2, 8'h00, 1'b1, 1'b0);
      tick();
      chk("b2_count", 32'(count), 2);
      chk("b2_ready", 32'(in_ready), 0);
      push_set(32'h33333333, 5'd3, 8'h00, 1'b1, 1'b0);
      tick();
      chk("b3_count", 32'(count), 2);
      chk("b3_head", out_result, 32'h11111111);
      chk("b3_head_rd", 32'(out_rd), 1);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("pop1_count", 32'(count), 1);
      chk("pop1_ready", 32'(in_ready), 1);
      chk("pop1_head", out_result, 32'h22222222);
      tick();
      chk("pop2_valid", 32'(out_valid), 0);
      chk("pop2_count", 32'(count), 0);
      // flag mapping
      push_set(32'h40000000, 5'd7, 8'h82, 1'b1, 1'b1);
      tick(); in_valid = 1'b0;
      tick();
      chk("dz_fflags", 32'(fflags), 32'h08);
      push_set(32'h00000001, 5'd8, 8'h28, 1'b1, 1'b0);
      tick(); in_valid = 1'b0;
      tick();
      chk("uf_nx_fflags", 32'(fflags), 32'h0B);
      // CSR write concurrent with commit
      push_set(32'h00000002, 5'd9, 8'h20, 1'b1, 1'b0);
      tick(); in_valid = 1'b0; csr_we = 1'b1; csr_wdata = 5'd0;
      tick(); csr_we = 1'b0;
      chk("csr_commit_fflags", 32'(fflags), 32'h01);
      push_set(32'h00000003, 5'd10, 8'h04, 1'b0, 1'b0);
      tick(); in_valid = 1'b0;
      tick();
      chk("no_flags_en", 32'(fflags), 32'h01);
      // flush with full FIFO carrying NV entries
      out_ready = 1'b0;
      push_set(32'hAAAA0000, 5'd11, 8'h04, 1'b1, 1'b0);
      tick();
      push_set(32'hAAAA0001, 5'd12, 8'h04, 1'b1, 1'b0);
      tick();
      chk("pre_flush_count", 32'(count), 2);
      flush = 1'b1; out_ready = 1'b1;
      push_set(32'hBBBB0000, 5'd13, 8'h04, 1'b1, 1'b0);
      tick(); flush = 1'b0; in_valid = 1'b0;
      chk("flush_count", 32'(count), 0);
      chk("flush_valid", 32'(out_valid), 0);
      chk("flush_fflags", 32'(fflags), 32'h01);
      tick();
      chk("post_flush_count", 32'(count), 0);
      csr_we = 1'b1; csr_wdata = 5'd0;
      tick(); csr_we = 1'b0;
      chk("csr_clear", 32'(fflags), 0);
      // back-to-back stream, pointers wrap
      for (int i = 0; i < 10; i++) begin
         push_set(32'h100 + 32'(i), 5'(i), 8'h00, 1'b1, 1'b0);
         tick();
         chk($sformatf("stream%0d_result", i), out_result, 32'h100 + 32'(i));
         chk($sformatf("stream%0d_count", i), 32'(count), 1);
         chk($sformatf("stream%0d_ready", i), 32'(in_ready), 1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drain", 32'(count), 0);
      // stream with asynchronous reset mid-way
      for (int i = 0; i < 4; i++) begin
         push_set(32'h200 + 32'(i), 5'(i), 8'h00, 1'b1, 1'b0);
         tick();
         chk($sformatf("rs%0d_result", i), out_result, 32'h200 + 32'(i));
      end
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_result", out_result, 0);
      chk("arst_ready", 32'(in_ready), 1);
      #1 rst_n = 1'b1;
      for (int i = 4; i < 8; i++) begin
         push_set(32'h200 + 32'(i), 5'(i), 8'h00, 1'b1, 1'b0);
         tick();
         chk($sformatf("rs%0d_result", i), out_result, 32'h200 + 32'(i));
         chk($sformatf("rs%0d_count", i), 32'(count), 1);
      end
      in_valid = 1'b0;
      tick();
      chk("rs_drain", 32'(count), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
